// File: rtl/mipi_power_sequencer_if.sv
// Avalon-MM register port of the MIPI sensor power sequencer (zero wait states).
interface mipi_power_sequencer_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/mipi_power_sequencer.sv
// Sequences a MIPI sensor's pwdn_n/reset_n pins through timed power-up and
// power-down phases, with a status/abort-count register port.
module mipi_power_sequencer #(
   parameter int unsigned T_PWR    = 1000,
   parameter int unsigned T_SETTLE = 2000,
   parameter int unsigned T_OFF    = 100
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         pwdn_n_req,
   mipi_power_sequencer_if.slave        bus,
   output logic                         mipi_pwdn_n,
   output logic                         mipi_reset_n,
   output logic                         mipi_ready,
   output logic                         busy
);

   typedef enum logic [2:0] {
      S_OFF      = 3'd0,
      S_PWR_WAIT = 3'd1,
      S_SETTLE   = 3'd2,
      S_ON       = 3'd3,
      S_SHUTDOWN = 3'd4
   } state_e;

   // Pin bundle order: {pwdn_n, reset_n, ready, busy}
   typedef logic [3:0] pins_t;

   localparam logic [15:0] LOAD_PWR    = 16'(T_PWR - 1);
   localparam logic [15:0] LOAD_SETTLE = 16'(T_SETTLE - 1);
   localparam logic [15:0] LOAD_OFF    = 16'(T_OFF - 1);

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  abort_q, abort_d;
   pins_t       pins_q, pins_d;
   logic        abort_clr;

   assign abort_clr = bus.chipselect && !bus.write_n && (bus.address == 2'd1);

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      state_d = state_q;
      cnt_d   = cnt_q;
      abort_d = abort_q;

      unique case (state_q)
         S_OFF: begin
            if (pwdn_n_req) begin
               state_d = S_PWR_WAIT;
               cnt_d   = LOAD_PWR;
            end
         end
         S_PWR_WAIT, S_SETTLE, S_ON: begin
            if (!pwdn_n_req) begin
               state_d = S_SHUTDOWN;
               cnt_d   = LOAD_OFF;
               if (state_q != S_ON && abort_q != 8'hFF) abort_d = abort_q + 8'd1;
            end else if (state_q == S_PWR_WAIT && cnt_q == 16'd0) begin
               state_d = S_SETTLE;
               cnt_d   = LOAD_SETTLE;
            end else if (state_q == S_SETTLE && cnt_q == 16'd0) begin
               state_d = S_ON;
               cnt_d   = 16'd0;
            end else if (state_q != S_ON) begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         S_SHUTDOWN: begin
            if (cnt_q == 16'd0) begin
               state_d = S_OFF;
               cnt_d   = 16'd0;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         default: begin
            state_d = S_OFF;
            cnt_d   = 16'd0;
         end
      endcase

      // A register clear beats an abort landing in the same cycle
      if (abort_clr) abort_d = 8'd0;

      // Pins follow the next state so they change on the edge that makes the decision
      unique case (state_d)
         S_PWR_WAIT: pins_d = 4'b1001;
         S_SETTLE:   pins_d = 4'b1101;
         S_ON:       pins_d = 4'b1110;
         S_SHUTDOWN: pins_d = 4'b1001;
         default:    pins_d = 4'b0000;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (reset) begin
         state_q <= S_OFF;
         cnt_q   <= 16'd0;
         abort_q <= 8'd0;
         pins_q  <= 4'b0000;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         abort_q <= abort_d;
         pins_q  <= pins_d;
      end
   end

   assign mipi_pwdn_n  = pins_q[3];
   assign mipi_reset_n = pins_q[2];
   assign mipi_ready   = pins_q[1];
   assign busy         = pins_q[0];

   always_comb begin
      bus.readdata = 32'd0;
      unique case (bus.address)
         2'd0:    bus.readdata = {25'd0, state_q, busy, mipi_ready, mipi_reset_n, mipi_pwdn_n};
         2'd1:    bus.readdata = {24'd0, abort_q};
         default: bus.readdata = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_mipi_power_sequencer.sv
// Bench for mipi_power_sequencer: directed timing scenarios plus randomized traffic
// checked against an elapsed-time model of the power phases.
module tb_mipi_power_sequencer;
   localparam int TP = 4;
   localparam int TS = 6;
   localparam int TO = 3;

   localparam int P_OFF = 0, P_PW = 1, P_SET = 2, P_ON = 3, P_SHUT = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic req = 1'b0;
   logic mipi_pwdn_n, mipi_reset_n, mipi_ready, busy;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   mipi_power_sequencer_if bus ();

   mipi_power_sequencer #(.T_PWR(TP), .T_SETTLE(TS), .T_OFF(TO)) dut (
      .clk          (clk),
      .reset        (reset),
      .pwdn_n_req   (req),
      .bus          (bus),
      .mipi_pwdn_n  (mipi_pwdn_n),
      .mipi_reset_n (mipi_reset_n),
      .mipi_ready   (mipi_ready),
      .busy         (busy)
   );

   // Model: which way the sensor is moving and how many edges since that began.
   int m_mode = 0;   // 0 idle, 1 powering up, 2 powering down
   int m_age  = 0;
   int m_abort = 0;

   // {pwdn_n, reset_n, ready, busy} for each phase
   logic [3:0] pin_table [0:4] = '{4'b0000, 4'b1001, 4'b1101, 4'b1110, 4'b1001};

   function automatic int phase();
      if (m_mode == 1) begin
         if (m_age < TP) return P_PW;
         if (m_age < TP + TS) return P_SET;
         return P_ON;
      end
      if (m_mode == 2 && m_age < TO) return P_SHUT;
      return P_OFF;
   endfunction

   function automatic void model_edge(input logic r, input logic q, input logic clr);
      int p;
      if (r) begin
         m_mode = 0; m_age = 0; m_abort = 0;
         return;
      end
      p = phase();
      if (p == P_OFF) begin
         if (q) begin m_mode = 1; m_age = 0; end
         else m_mode = 0;
      end else if (p == P_SHUT) begin
         m_age++;
      end else if (!q) begin
         if (p != P_ON) m_abort = (m_abort < 255) ? m_abort + 1 : 255;
         m_mode = 2; m_age = 0;
      end else begin
         m_age++;
      end
      if (clr) m_abort = 0;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic compare_model();
      int p;
      logic [3:0]  pins;
      logic [31:0] exp_rd;
      p = phase();
      pins = pin_table[p];
      check("pins", {28'd0, mipi_pwdn_n, mipi_reset_n, mipi_ready, busy}, {28'd0, pins});
      case (bus.address)
         2'd0:    exp_rd = {25'd0, 3'(p), pins[0], pins[1], pins[2], pins[3]};
         2'd1:    exp_rd = 32'(m_abort);
         default: exp_rd = 32'd0;
      endcase
      check("readdata", bus.readdata, exp_rd);
   endtask

   task automatic step(input logic r, input logic q, input logic [1:0] a,
                       input logic cs, input logic wn);
      reset = r;
      req = q;
      bus.address = a;
      bus.chipselect = cs;
      bus.write_n = wn;
      bus.writedata = $urandom;
      @(posedge clk);
      model_edge(r, q, cs && !wn && (a == 2'd1));
      #1;
      compare_model();
   endtask

   task automatic tick(input logic r, input logic q);
      step(r, q, 2'd0, 1'b0, 1'b1);
   endtask

   task automatic peek(input logic [1:0] a, output logic [31:0] d);
      bus.address = a;
      #1;
      d = bus.readdata;
   endtask

   initial begin
      logic [31:0] rd;
      logic        q;
      int          code;

      bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'd0;

      // Reset state
      tick(1, 0); tick(1, 0);
      check("rst_status", bus.readdata, 32'd0);
      tick(0, 0);

      // Power-up from edge 0
      for (int i = 0; i < 12; i++) begin
         tick(0, 1);
         check("pu_pwdn_n", 32'(mipi_pwdn_n), 32'd1);
         check("pu_reset_n", 32'(mipi_reset_n), 32'(i >= 4));
         check("pu_ready", 32'(mipi_ready), 32'(i >= 10));
         check("pu_busy", 32'(busy), 32'(i <= 9));
      end

      // Power-down from ON at edge k
      for (int i = 0; i < 5; i++) begin
         tick(0, 0);
         check("pd_reset_n", 32'(mipi_reset_n), 32'd0);
         check("pd_ready", 32'(mipi_ready), 32'd0);
         check("pd_pwdn_n", 32'(mipi_pwdn_n), 32'(i < 3));
         check("pd_busy", 32'(busy), 32'(i <= 2));
      end

      // Abort two cycles after reset release
      for (int i = 0; i < 6; i++) tick(0, 1);
      tick(0, 0);
      peek(2'd1, rd);
      check("abort_cnt", rd, 32'd1);
      peek(2'd0, rd);
      check("abort_code", 32'(rd[6:4]), 32'd4);
      for (int i = 0; i < 3; i++) tick(0, 0);

      // Re-request during SHUTDOWN
      for (int i = 0; i < 12; i++) tick(0, 1);
      tick(0, 0);
      for (int j = 1; j <= 8; j++) begin
         tick(0, 1);
         code = (j < 3) ? 4 : (j == 3) ? 0 : (j < 8) ? 1 : 2;
         check("rereq_code", 32'(bus.readdata[6:4]), 32'(code));
      end

      // Reset while in SETTLE, then immediate restart with req held high
      tick(1, 1);
      check("rst_settle_pins", {28'd0, mipi_pwdn_n, mipi_reset_n, mipi_ready, busy}, 32'd0);
      check("rst_settle_status", bus.readdata, 32'd0);
      tick(0, 1);
      check("post_rst_code", 32'(bus.readdata[6:4]), 32'd1);
      tick(0, 0);
      for (int i = 0; i < 3; i++) tick(0, 0);

      // Saturation of the abort counter
      for (int n = 0; n < 260; n++) begin
         tick(0, 1);
         tick(0, 0);
         for (int i = 0; i < 3; i++) tick(0, 0);
      end
      peek(2'd1, rd);
      check("abort_sat", rd, 32'd255);
      step(0, 0, 2'd2, 1'b1, 1'b0);
      step(0, 0, 2'd0, 1'b1, 1'b0);
      peek(2'd1, rd);
      check("no_clr_other_addr", rd, 32'd255);

      // Clear coinciding with an abort
      tick(0, 1);
      step(0, 0, 2'd1, 1'b1, 1'b0);
      check("clr_wins", bus.readdata, 32'd0);
      for (int i = 0; i < 3; i++) tick(0, 0);

      // Randomized traffic
      q = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 15) == 0) q = ~q;
         step($urandom_range(0, 199) == 0, q, 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), $urandom_range(0, 7) != 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mipi_power_sequencer.md
MIPI_POWER_SEQUENCER -- requirements
Module: mipi_power_sequencer

Interface
REQ-001 Parameter T_PWR, default 1000, meaning cycles with pwdn_n released and reset_n held low before reset release; legal range 1..65535.
REQ-002 Parameter T_SETTLE, default 2000, meaning cycles after reset release before the sensor is declared ready; legal range 1..65535.
REQ-003 Parameter T_OFF, default 100, meaning cycles between reset_n assertion and pwdn_n assertion on shutdown; legal range 1..65535.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous active-high reset.
- pwdn_n_req  in  1  power request from the upstream PIO out_port (clk domain); 1 = power on.
- address  in  2  Avalon-MM slave word address.
- chipselect  in  1  Avalon-MM slave select.
- write_n  in  1  Avalon-MM write strobe, active low.
- writedata  in  32  Avalon-MM write data.
- readdata  out  32  Avalon-MM read data; zero wait states.
- mipi_pwdn_n  out  1  sensor power-down pin; 0 = powered down.
- mipi_reset_n  out  1  sensor reset pin; 0 = in reset.
- mipi_ready  out  1  sensor powered and settled.
- busy  out  1  sequence in progress.

Function
REQ-005 States SHALL be OFF, PWR_WAIT, SETTLE, ON and SHUTDOWN; all four outputs SHALL be registered.
REQ-006 Output values per state SHALL be as follows (pwdn_n, reset_n, ready, busy):
- OFF: 0,0,0,0.
- PWR_WAIT: 1,0,0,1.
- SETTLE: 1,1,0,1.
- ON: 1,1,1,0.
- SHUTDOWN: 1,0,0,1.
REQ-007 From OFF, pwdn_n_req=1 sampled at an edge SHALL enter PWR_WAIT at that edge, so outputs change at the same edge that samples the request.
REQ-008 PWR_WAIT SHALL last exactly T_PWR cycles and then enter SETTLE; SETTLE SHALL last exactly T_SETTLE cycles and then enter ON.
REQ-009 A 16-bit down-counter SHALL be loaded with (duration-1) on each state entry, and the transition SHALL occur at the edge where the counter is 0.
REQ-010 pwdn_n_req=0 sampled in PWR_WAIT, SETTLE or ON SHALL enter SHUTDOWN at that edge, so mipi_reset_n falls with no delay.
REQ-011 SHUTDOWN SHALL last exactly T_OFF cycles and then enter OFF, regardless of pwdn_n_req.
REQ-012 pwdn_n_req=1 during SHUTDOWN SHALL be ignored until OFF; OFF SHALL then be held for at least 1 cycle before PWR_WAIT is entered.
REQ-013 pwdn_n_req=0 in OFF, and pwdn_n_req=1 in ON, SHALL hold the current state.
REQ-014 An abort counter (8-bit, saturating at 255) SHALL increment on each PWR_WAIT->SHUTDOWN or SETTLE->SHUTDOWN transition.
REQ-015 Register map (readdata is combinational from address; chipselect is not required for reads):
- addr 0 status: bit0 mipi_pwdn_n, bit1 mipi_reset_n, bit2 mipi_ready, bit3 busy, bits6:4 state code (OFF=0, PWR_WAIT=1, SETTLE=2, ON=3, SHUTDOWN=4), bits31:7 = 0.
- addr 1: bits7:0 abort counter, bits31:8 = 0.
- addr 2-3: read 0.
REQ-016 A write (chipselect=1, write_n=0) to address 1 SHALL clear the abort counter; if an abort occurs in the same cycle, the clear SHALL win.
REQ-017 Writes to addresses 0, 2 and 3 SHALL have no effect.

Reset
REQ-018 reset=1 at an edge SHALL force state OFF, counter 0, abort counter 0 and outputs 0,0,0,0, overriding any state mid-sequence.
REQ-019 Reset mid-sequence SHALL drop mipi_pwdn_n immediately, with no T_OFF delay.
REQ-020 After reset deasserts, a pwdn_n_req already at 1 SHALL start PWR_WAIT at the first non-reset edge.

Verification (T_PWR=4, T_SETTLE=6, T_OFF=3)
REQ-021 Power-up: req rises at edge 0 -> pwdn_n=1 from edge 0, reset_n=1 from edge 4, ready=1 from edge 10, busy=1 over edges 0-9.
REQ-022 Power-down from ON: req falls at edge k -> reset_n=0 and ready=0 at edge k, pwdn_n=0 at edge k+3, busy=1 over edges k..k+2.
REQ-023 Abort in SETTLE: req falls 2 cycles after reset release -> SHUTDOWN entered, abort counter=1, addr 1 reads 0x00000001, addr 0 bits6:4 = 4 during SHUTDOWN.
REQ-024 Re-request during SHUTDOWN: req returns to 1 one cycle after falling -> full T_OFF completes, OFF held 1 cycle, then PWR_WAIT with T_PWR=4 restarts.
REQ-025 Saturation and clear: 260 aborts -> addr 1 reads 255; write addr 1 in the same cycle as an abort -> counter reads 0.
REQ-026 Reset in SETTLE: reset=1 -> next edge outputs 0,0,0,0 and status reads 0x00000000.
